pmem_lat: RTL

- Clocked, parametrised successor to the combinational DPI physical-memory model.
- Holds an internal word-array backing store and serves one request at a time.
- Uses a valid/ready request channel and a valid/ready response channel, with a programmable fixed access latency.
- Sits between the core's LSU/IFU and memory. It lets the pipeline be exercised against realistic multi-cycle memory with back-pressure, address-range errors and byte-masked writes.

---
 rtl/pmem_lat_if.sv | 26 ++
 rtl/pmem_lat.sv | 102 ++++++++++
 2 files changed

// File: rtl/pmem_lat_if.sv
// Request/response bus between an LSU/IFU-style master and the pmem_lat memory model.
interface pmem_lat_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wen;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wmask;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/pmem_lat.sv
// Clocked physical-memory model: word-array store, one request at a time,
// fixed programmable latency, byte-masked writes and range/alignment faults.
module pmem_lat #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned           LATENCY    = 1
) (
    input logic       clk,
    input logic       rst,
    pmem_lat_if.slave bus
);
    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = $clog2(BYTES);
    localparam int unsigned IDX_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   word_off;
    logic [IDX_BITS-1:0]     idx;
    logic                    addr_err;
    logic                    accept;

    // Subtraction wraps modulo 2^ADDR_WIDTH; the below-base test catches wrapped addresses.
    assign offset   = bus.req_addr - BASE_ADDR;
    assign word_off = offset >> OFF_BITS;
    assign idx      = word_off[IDX_BITS-1:0];
    assign addr_err = (bus.req_addr < BASE_ADDR)
                   || (word_off >= ADDR_WIDTH'(DEPTH))
                   || (bus.req_addr[OFF_BITS-1:0] != '0);

    assign accept        = bus.req_valid && (state == IDLE) && !rst;
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Store is never reset; writes commit on the accept edge itself.
    always_ff @(posedge clk) begin
        if (accept && bus.req_wen && !addr_err) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (bus.req_wmask[i]) begin
                    mem[idx][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cnt         <= CNT_W'(LATENCY - 1);
                        rsp_err_q   <= addr_err;
                        rsp_rdata_q <= (!addr_err && !bus.req_wen) ? mem[idx] : '0;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Leaving on the edge that takes the count to zero makes rsp_valid
                    // sampled high exactly LATENCY edges after accept.
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
